// File: rtl/ahb_to_ri5cy_mem_pkg.sv
// Shared AHB-Lite encodings used by the slave bridge and the core-side master bridges.
package ahb_to_ri5cy_mem_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

endpackage

// File: rtl/ahb_to_ri5cy_mem_if.sv
// Bundles the AHB-Lite slave port and the RI5CY req/gnt/rvalid memory port of the bridge.
interface ahb_to_ri5cy_mem_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          hsel;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hwdata;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [3:0]    hprot;
  logic [1:0]    htrans;
  logic          hmastlock;
  logic          hready;
  logic [DW-1:0] hrdata;
  logic          hreadyout;
  logic          hresp;

  logic          req;
  logic          we;
  logic [3:0]    be;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  // The bridge's own view: AHB requests in, memory requests out.
  modport slave (
    input  hsel, haddr, hwdata, hwrite, hsize, hburst, hprot, htrans, hmastlock, hready,
    output hrdata, hreadyout, hresp,
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  // The surrounding system: AHB master plus the memory behind the bridge.
  modport master (
    output hsel, haddr, hwdata, hwrite, hsize, hburst, hprot, htrans, hmastlock, hready,
    input  hrdata, hreadyout, hresp,
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ahb_to_ri5cy_mem_lane_decode.sv
// Maps the low address bits and transfer size onto 32-bit byte lanes and flags
// transfers that are oversized or not naturally aligned.
module ahb_to_ri5cy_mem_lane_decode
  import ahb_to_ri5cy_mem_pkg::*;
(
  input  logic [1:0] addr_lsb,
  input  logic [2:0] size,
  output logic [3:0] be,
  output logic       misalign_err
);

  always_comb begin
    be           = 4'b0000;
    misalign_err = 1'b0;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr_lsb;
      HSIZE_HALF: begin
        be           = 4'b0011 << addr_lsb;
        misalign_err = addr_lsb[0];
      end
      HSIZE_WORD: begin
        be           = 4'b1111;
        misalign_err = (addr_lsb != 2'b00);
      end
      default:    misalign_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_to_ri5cy_mem.sv
// AHB-Lite slave that turns single-beat bus transfers into RI5CY req/gnt/rvalid
// memory accesses, one transfer outstanding at a time.
module ahb_to_ri5cy_mem
  import ahb_to_ri5cy_mem_pkg::*;
#(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rstn,
  ahb_to_ri5cy_mem_if.slave bus
);

  if (AHB_DATA_WIDTH != 32) begin : g_dw_check
    $error("ahb_to_ri5cy_mem: AHB_DATA_WIDTH must be 32");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t                    state_q, state_d;
  logic [AHB_ADDR_WIDTH-1:0] addr_q;
  logic                      write_q;
  logic [3:0]                be_q;
  logic [AHB_DATA_WIDTH-1:0] hrdata_q;

  logic [3:0] dec_be;
  logic       dec_err;
  logic       can_accept;
  logic       accept;
  logic       hreadyout;
  hresp_t     hresp;
  logic       req;
  logic       unused_ok;

  ahb_to_ri5cy_mem_lane_decode u_lane_decode (
    .addr_lsb     (bus.haddr[1:0]),
    .size         (bus.hsize),
    .be           (dec_be),
    .misalign_err (dec_err)
  );

  // A new address phase is only looked at when the previous data phase is completing.
  always_comb begin
    can_accept = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
    accept     = can_accept && bus.hsel && bus.hready &&
                 ((bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ));
  end

  always_comb begin
    state_d   = state_q;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    req       = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (state_q == ST_ERR2) hresp = HRESP_ERROR;
        if (accept) state_d = dec_err ? ST_ERR1 : ST_REQ;
        else        state_d = ST_IDLE;
      end
      ST_REQ: begin
        req       = 1'b1;
        hreadyout = 1'b0;
        if (bus.gnt) state_d = ST_RESP;
      end
      ST_RESP: begin
        hreadyout = 1'b0;
        if (bus.rvalid) state_d = ST_DONE;
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Transfer attributes are held for the whole access; read data is held until the next read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      be_q     <= 4'b0000;
      hrdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= {bus.haddr[AHB_ADDR_WIDTH-1:2], 2'b00};
        write_q <= bus.hwrite;
        be_q    <= dec_be;
      end
      if ((state_q == ST_RESP) && bus.rvalid && !write_q) begin
        hrdata_q <= bus.rdata;
      end
    end
  end

  assign bus.hreadyout = hreadyout;
  assign bus.hresp     = hresp;
  assign bus.hrdata    = hrdata_q;
  assign bus.req       = req;
  assign bus.we        = write_q;
  assign bus.be        = be_q;
  assign bus.addr      = addr_q;
  assign bus.wdata     = bus.hwdata;

  assign unused_ok = ^{bus.hburst, bus.hprot, bus.hmastlock};

endmodule
